// File: rtl/contador_display_7seg.sv
// Two-digit multiplexed common-anode 7-segment driver for a 4-bit counter value (0..15).
// Optional macro CONTADOR_DISPLAY_DIR_EN lights the units decimal point while the value is counting down.
module contador_display_7seg #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] valor_entrada,
   input  logic       carrega,
   output logic [6:0] segmentos,
   output logic [1:0] anodos,
   output logic       dp
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] ULTIMO = CW'(SCAN_DIV - 1);

   typedef enum logic {DIG_UNI, DIG_DEZ} estado_t;

   estado_t       estado;
   logic [CW-1:0] contador;
   logic [3:0]    valor;
   logic          dezena;
   logic [3:0]    unidade;

   function automatic logic [6:0] decodifica(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   always_comb begin
      dezena  = 1'b0;
      unidade = valor;
      if (valor >= 4'd10) begin
         dezena  = 1'b1;
         unidade = valor - 4'd10;
      end
   end

   // Outputs are computed from the pre-edge state and held value, so a load or
   // a scan wrap becomes visible one edge later.
   always_ff @(posedge clock) begin
      if (reset) begin
         valor     <= 4'd0;
         contador  <= '0;
         estado    <= DIG_UNI;
         segmentos <= 7'h7F;
         anodos    <= 2'b11;
      end else begin
         if (carrega)
            valor <= valor_entrada;

         if (contador == ULTIMO) begin
            contador <= '0;
            estado   <= (estado == DIG_UNI) ? DIG_DEZ : DIG_UNI;
         end else begin
            contador <= contador + 1'b1;
         end

         case (estado)
            DIG_UNI: begin
               anodos    <= 2'b10;
               segmentos <= decodifica(unidade);
            end
            default: begin
               if (dezena) begin
                  anodos    <= 2'b01;
                  segmentos <= decodifica(4'd1);
               end else begin
                  anodos    <= 2'b11;
                  segmentos <= 7'h7F;
               end
            end
         endcase
      end
   end

`ifdef CONTADOR_DISPLAY_DIR_EN
   logic desce;

   // Direction is judged against the held value before it is overwritten.
   always_ff @(posedge clock) begin
      if (reset) begin
         desce <= 1'b0;
         dp    <= 1'b1;
      end else begin
         dp <= !((estado == DIG_UNI) && desce);
         if (carrega) begin
            if (valor_entrada < valor)
               desce <= 1'b1;
            else if (valor_entrada > valor)
               desce <= 1'b0;
         end
      end
   end
`else
   assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_contador_display_7seg.sv
// Randomized bench for contador_display_7seg with a cycle-count reference model.
module tb_contador_display_7seg;

   localparam int SCAN_DIV = 4;
`ifdef CONTADOR_DISPLAY_DIR_EN
   localparam logic DIR_EN = 1'b1;
`else
   localparam logic DIR_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] valor_entrada = 4'd0;
   logic       carrega = 1'b0;
   logic [6:0] segmentos;
   logic [1:0] anodos;
   logic       dp;

   int compared = 0;
   int mismatched = 0;

   contador_display_7seg #(.SCAN_DIV(SCAN_DIV)) dut (
      .clock(clock),
      .reset(reset),
      .valor_entrada(valor_entrada),
      .carrega(carrega),
      .segmentos(segmentos),
      .anodos(anodos),
      .dp(dp)
   );

   always #5 clock = ~clock;

   logic [6:0] seg_tab [10];
   initial begin
      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
      seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0010000;
   end

   // Reference model: digit phase derived from edges elapsed since reset.
   int         m_held = 0;
   int         m_k = 0;
   logic       m_desce = 1'b0;
   logic       model_valid = 1'b0;
   logic [6:0] exp_seg = 7'h7F;
   logic [1:0] exp_an = 2'b11;
   logic       exp_dp = 1'b1;

   always @(posedge clock) begin
      if (reset) begin
         exp_seg = 7'h7F; exp_an = 2'b11; exp_dp = 1'b1;
         m_held = 0; m_k = 0; m_desce = 1'b0;
      end else begin
         bit tens_phase;
         tens_phase = ((m_k / SCAN_DIV) % 2) == 1;
         if (!tens_phase) begin
            exp_an = 2'b10; exp_seg = seg_tab[m_held % 10];
         end else if (m_held >= 10) begin
            exp_an = 2'b01; exp_seg = seg_tab[m_held / 10];
         end else begin
            exp_an = 2'b11; exp_seg = 7'h7F;
         end
         exp_dp = DIR_EN ? !(!tens_phase && m_desce) : 1'b1;
         if (carrega) begin
            if (int'(valor_entrada) < m_held) m_desce = 1'b1;
            else if (int'(valor_entrada) > m_held) m_desce = 1'b0;
            m_held = int'(valor_entrada);
         end
         m_k = (m_k + 1) % (2 * SCAN_DIV);
      end
      model_valid = 1'b1;
   end

   task automatic check(input string nome, input logic [6:0] atual, input logic [6:0] esperado);
      compared++;
      if (atual !== esperado) begin
         mismatched++;
         $display("FAIL %s: got %b, expected %b at %0t", nome, atual, esperado, $time);
      end
   endtask

   always @(negedge clock) begin
      if (model_valid) begin
         check("model_seg", segmentos, exp_seg);
         check("model_an", {5'b0, anodos}, {5'b0, exp_an});
         check("model_dp", {6'b0, dp}, {6'b0, exp_dp});
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic pin(input string nome, input logic [1:0] an, input logic [6:0] seg);
      check({nome, "_an"}, {5'b0, anodos}, {5'b0, an});
      check({nome, "_seg"}, segmentos, seg);
   endtask

   initial begin
      tick(3);
      reset = 1'b0;
      tick(1);                                   // E1
      pin("rel_e1", 2'b10, 7'b1000000);
      check("rel_e1_dp", {6'b0, dp}, 7'd1);
      tick(4);                                   // E5
      pin("blank_tens", 2'b11, 7'b1111111);
      tick(4);                                   // E9
      pin("back_units", 2'b10, 7'b1000000);
      valor_entrada = 4'd7; carrega = 1'b1;
      tick(1);                                   // E10
      carrega = 1'b0;
      tick(1);                                   // E11
      pin("load7_u", 2'b10, 7'b1111000);
      tick(2);                                   // E13
      pin("load7_t", 2'b11, 7'b1111111);
      valor_entrada = 4'd13; carrega = 1'b1;
      tick(1);                                   // E14
      carrega = 1'b0;
      tick(1);                                   // E15
      pin("load13_t", 2'b01, 7'b1111001);
      tick(2);                                   // E17
      pin("load13_u", 2'b10, 7'b0110000);
      valor_entrada = 4'd9; carrega = 1'b1;
      tick(1);                                   // E18
      carrega = 1'b0;
      tick(1);                                   // E19
      valor_entrada = 4'd15; carrega = 1'b1;
      tick(1);                                   // E20 wrap edge
      carrega = 1'b0;
      pin("wrap_old", 2'b10, 7'b0010000);
      tick(1);                                   // E21
      pin("wrap_new", 2'b01, 7'b1111001);
      tick(1);                                   // E22
      valor_entrada = 4'd12; carrega = 1'b1;
      tick(1);                                   // E23
      carrega = 1'b0; reset = 1'b1;
      tick(1);                                   // E24
      pin("mid_reset", 2'b11, 7'h7F);
      check("mid_reset_dp", {6'b0, dp}, 7'd1);
      reset = 1'b0;
      tick(1);                                   // E25
      pin("after_reset", 2'b10, 7'b1000000);
      valor_entrada = 4'd14; carrega = 1'b1;
      tick(1);                                   // E26
      carrega = 1'b0;
      tick(1);                                   // E27
      check("dir_14_dp", {6'b0, dp}, 7'd1);
      valor_entrada = 4'd15; carrega = 1'b1;
      tick(1);                                   // E28
      valor_entrada = 4'd14;
      tick(1);                                   // E29
      carrega = 1'b0;
      check("dir_15_dp", {6'b0, dp}, 7'd1);
      tick(4);                                   // E33
      check("dir_down_dp", {6'b0, dp}, DIR_EN ? 7'd0 : 7'd1);
      valor_entrada = 4'd14; carrega = 1'b1;
      tick(1);                                   // E34
      carrega = 1'b0;
      tick(1);                                   // E35
      check("dir_equal_dp", {6'b0, dp}, DIR_EN ? 7'd0 : 7'd1);

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(99) == 0);
         carrega = ($urandom_range(3) == 0);
         valor_entrada = 4'($urandom_range(15));
         tick(1);
      end
      reset = 1'b0; carrega = 1'b0;
      tick(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
